pc_next_unit: RTL and testbench

//  Parametrised fetch-address generator for the 5-stage core; replaces the plain enable-gated PC register.

---
 rtl/pc_pkg.sv | 17 +
 rtl/ras_stack.sv | 57 +++++
 rtl/pc_next_unit.sv | 117 +++++++++++
 tb/tb_pc_next_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the fetch-address generator
package pc_pkg;

  localparam int PC_XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  // Low-bit mask a target must clear to be a legal instruction address.
  function automatic int unsigned ialign_mask(input int unsigned ialign);
    return ialign - 1;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; overflow drops the oldest entry
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  assign empty  = (count_q == '0);
  assign do_pop = pop && !empty;
  assign top    = empty ? '0 : mem_q[ptr_q];

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push && do_pop) begin
      mem_d[ptr_q] = push_data;
    end else if (push) begin
      // Pointer wraps, so a full stack silently overwrites its oldest slot.
      ptr_d        = ptr_q + 1'b1;
      mem_d[ptr_d] = push_data;
      if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
    end else if (do_pop) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - fetch PC register with boot/run/halt FSM and priority next-PC mux
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               IALIGN       = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            call_valid,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_seq,
  output logic            misaligned,
  output logic [XLEN-1:0] ret_pred_pc,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ialign_mask(IALIGN));

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic            ras_push, ras_pop;
  logic            trap_bad, redirect_bad;

  assign pc           = pc_q;
  assign pc_seq       = pc_q + XLEN'(IALIGN);
  assign pc_valid     = (state_q == ST_RUN);
  assign misaligned   = misaligned_q;
  assign trap_bad     = |(trap_vector & ALIGN_MASK);
  assign redirect_bad = |(redirect_pc & ALIGN_MASK);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap_valid) begin
          if (trap_bad) misaligned_d = 1'b1;
          else          pc_d = trap_vector;
        end else if (redirect_valid) begin
          if (redirect_bad) misaligned_d = 1'b1;
          else              pc_d = redirect_pc;
        end else if (halt_req) begin
          // The current fetch completes; pc stays so resume continues after it.
          state_d = ST_HALT;
        end else begin
          ras_push = en && call_valid;
          ras_pop  = en && ret_valid;
          if (en && ret_valid && !ras_empty) pc_d = ret_pred_pc;
          else if (en)                       pc_d = pc_seq;
        end
      end
      ST_HALT: begin
        if (trap_valid) begin
          state_d = ST_RUN;
          if (trap_bad) misaligned_d = 1'b1;
          else          pc_d = trap_vector;
        end else if (resume) begin
          state_d = ST_RUN;
          if (en) pc_d = pc_seq;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifdef PC_RAS_EN
  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ret_pred_pc),
    .empty     (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic          unused_ras_sigs;
  assign unused_ras_sigs = ^{ras_push, ras_pop};
  assign ret_pred_pc     = '0;
  assign ras_empty       = 1'b1;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed self-checking bench for pc_next_unit
module tb_pc_next_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic        resume;
  logic        call_valid;
  logic        ret_valid;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_seq;
  logic        misaligned;
  logic [31:0] ret_pred_pc;
  logic        ras_empty;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  pc_next_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .IALIGN       (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .halt_req       (halt_req),
    .resume         (resume),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pc_seq         (pc_seq),
    .misaligned     (misaligned),
    .ret_pred_pc    (ret_pred_pc),
    .ras_empty      (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] addr);
    en             = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_vector = '0; halt_req = 1'b0; resume = 1'b0;
    call_valid = 1'b0; ret_valid = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 32'h100);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_ras_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_ret_pred", ret_pred_pc, 32'h0);

    reset = 1'b0; en = 1'b1;
    tick();
    chk("boot_pc", pc, 32'h100);
    chk("boot_valid", {31'd0, pc_valid}, 32'd1);
    chk("boot_pc_seq", pc_seq, 32'h104);
    tick();
    chk("seq_pc", pc, 32'h104);

    load(32'h200);
    chk("load_200", pc, 32'h200);
    tick();
    chk("stall_pc", pc, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    chk("flush_pc", pc, 32'h400);

    trap_valid = 1'b1; trap_vector = 32'h80;
    tick();
    chk("trap_prio_pc", pc, 32'h80);
    trap_valid = 1'b0; redirect_pc = 32'h402;
    tick();
    chk("mis_redir_pc", pc, 32'h80);
    chk("mis_redir_flag", {31'd0, misaligned}, 32'd1);
    redirect_valid = 1'b0;
    tick();
    chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    chk("mis_hold_pc", pc, 32'h80);
    trap_valid = 1'b1; trap_vector = 32'h86;
    tick();
    trap_valid = 1'b0;
    chk("mis_trap_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_trap_pc", pc, 32'h80);

    load(32'hFFFF_FFFC);
    chk("wrap_load", pc, 32'hFFFF_FFFC);
    chk("wrap_load_mis", {31'd0, misaligned}, 32'd0);
    en = 1'b1;
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_mis", {31'd0, misaligned}, 32'd0);

    load(32'h300);
    halt_req = 1'b1; en = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_pc", pc, 32'h300);
    chk("halt_valid", {31'd0, pc_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      redirect_valid = (i == 2);
      redirect_pc    = 32'h500;
      tick();
      chk("halt_hold_pc", pc, 32'h300);
      chk("halt_hold_valid", {31'd0, pc_valid}, 32'd0);
    end
    redirect_valid = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_valid", {31'd0, pc_valid}, 32'd1);
    chk("resume_pc", pc, 32'h304);
    tick();
    chk("resume_seq", pc, 32'h308);

    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h600;
    tick();
    redirect_valid = 1'b0;
    chk("halt_vs_redir_pc", pc, 32'h600);
    chk("halt_vs_redir_valid", {31'd0, pc_valid}, 32'd1);
    tick();
    halt_req = 1'b0;
    chk("halt2_valid", {31'd0, pc_valid}, 32'd0);
    trap_valid = 1'b1; trap_vector = 32'h700;
    tick();
    trap_valid = 1'b0;
    chk("halt_trap_pc", pc, 32'h700);
    chk("halt_trap_valid", {31'd0, pc_valid}, 32'd1);

`ifdef PC_RAS_EN
    for (int k = 0; k < 5; k++) begin
      load(32'h10 * (k + 1));
      en = 1'b1; call_valid = 1'b1;
      tick();
      call_valid = 1'b0;
      chk("ras_call_pc", pc, 32'h10 * (k + 1) + 32'h4);
      chk("ras_call_top", ret_pred_pc, 32'h10 * (k + 1) + 32'h4);
    end
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; ret_valid = 1'b1;
      chk("ras_pred", ret_pred_pc, 32'h54 - 32'h10 * k);
      tick();
      chk("ras_ret_pc", pc, 32'h54 - 32'h10 * k);
    end
    chk("ras_drained", {31'd0, ras_empty}, 32'd1);
    tick();
    ret_valid = 1'b0;
    chk("ras_empty_ret_pc", pc, 32'h28);
    chk("ras_empty_ret_flag", {31'd0, ras_empty}, 32'd1);

    load(32'h50);
    en = 1'b1; call_valid = 1'b1;
    tick();
    call_valid = 1'b0;
    load(32'h60);
    en = 1'b1; call_valid = 1'b1; ret_valid = 1'b1;
    tick();
    call_valid = 1'b0;
    chk("ras_repl_pc", pc, 32'h54);
    chk("ras_repl_top", ret_pred_pc, 32'h64);
    chk("ras_repl_nonempty", {31'd0, ras_empty}, 32'd0);
    tick();
    ret_valid = 1'b0;
    chk("ras_repl_pop_pc", pc, 32'h64);
    chk("ras_repl_count", {31'd0, ras_empty}, 32'd1);
`else
    en = 1'b1; call_valid = 1'b1; ret_valid = 1'b1;
    tick();
    call_valid = 1'b0; ret_valid = 1'b0;
    chk("noras_pc", pc, 32'h704);
    chk("noras_empty", {31'd0, ras_empty}, 32'd1);
    chk("noras_pred", ret_pred_pc, 32'h0);
`endif

    reset = 1'b1; en = 1'b1; trap_valid = 1'b1; trap_vector = 32'h80;
    tick();
    reset = 1'b0; trap_valid = 1'b0;
    chk("midrst_pc", pc, 32'h100);
    chk("midrst_valid", {31'd0, pc_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
